// File: rtl/lisnoc_router_input_route.sv
// Router input port: per-vchannel input FIFO, header route lookup and worm streaming
// toward the switch request/flit/read interface consumed by the output-port arbiters.
module lisnoc_router_input_route #(
  parameter int unsigned flit_data_width = 32,
  parameter int unsigned flit_type_width = 2,
  parameter int unsigned ph_dest_width   = 5,
  parameter int unsigned num_dests       = 32,
  parameter int unsigned ports           = 5,
  parameter int unsigned vchannels       = 1,
  parameter int unsigned fifo_length     = 4,
  parameter logic [num_dests*ports-1:0] lookup = '0,
  localparam int unsigned flit_width = flit_data_width + flit_type_width
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [flit_width-1:0]           link_flit,
  input  logic [vchannels-1:0]            link_valid,
  output logic [vchannels-1:0]            link_ready,
  output logic [vchannels*ports-1:0]      switch_request,
  output logic [flit_width*vchannels-1:0] switch_flit,
  input  logic [vchannels*ports-1:0]      switch_read,
  output logic [vchannels-1:0]            drop_o
);

  localparam int unsigned ptr_w = (fifo_length > 1) ? $clog2(fifo_length) : 1;
  localparam int unsigned cnt_w = $clog2(fifo_length + 1);

  localparam logic [flit_type_width-1:0] type_header = flit_type_width'(1);
  localparam logic [flit_type_width-1:0] type_last   = flit_type_width'(2);
  localparam logic [flit_type_width-1:0] type_single = flit_type_width'(3);

  localparam logic [cnt_w-1:0] full_count = cnt_w'(fifo_length);

  typedef enum logic [1:0] {StIdle, StRoute, StDrop} state_e;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(fifo_length - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  for (genvar v = 0; v < vchannels; v++) begin : g_vc
    logic [flit_width-1:0]      mem_q [fifo_length];
    logic [ptr_w-1:0]           rd_ptr_q, wr_ptr_q;
    logic [cnt_w-1:0]           count_q, count_d;
    logic                       ready_q, drop_q;
    logic [ports-1:0]           route_q;
    state_e                     state_q;

    logic [flit_width-1:0]      head;
    logic [flit_type_width-1:0] head_type;
    logic [ph_dest_width-1:0]   dest;
    logic [31:0]                dest_ext;
    logic [ports-1:0]           dest_route, req;
    logic                       empty, push, pop, drop_pop, transfer;
    logic                       is_head, is_tail, routable;

    assign head      = mem_q[rd_ptr_q];
    assign head_type = head[flit_width-1 -: flit_type_width];
    assign dest      = head[flit_data_width-1 -: ph_dest_width];
    assign dest_ext  = 32'(dest);
    assign empty     = (count_q == '0);
    assign is_head   = (head_type == type_header) || (head_type == type_single);
    assign is_tail   = (head_type == type_last) || (head_type == type_single);

    // Destinations at or beyond num_dests match no entry and so read as unroutable.
    always_comb begin
      dest_route = '0;
      for (int d = 0; d < int'(num_dests); d++) begin
        if (dest_ext == 32'(d)) dest_route = lookup[d*ports +: ports];
      end
    end
    assign routable = |dest_route;

    // route_q is zero outside StRoute, so no state qualifier is needed here.
    assign req      = rst ? '0 : (route_q & {ports{~empty}});
    assign transfer = |(req & switch_read[v*ports +: ports]);

    assign link_ready[v]                         = ready_q & ~rst;
    assign push                                  = link_valid[v] & link_ready[v];
    assign switch_request[v*ports +: ports]      = req;
    assign switch_flit[v*flit_width +: flit_width] = head;
    assign drop_o[v]                             = drop_q & ~rst;

    always_comb begin
      pop      = 1'b0;
      drop_pop = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!empty && !(is_head && routable)) begin
            pop      = 1'b1;
            drop_pop = 1'b1;
          end
        end
        StRoute: pop = transfer;
        StDrop: begin
          if (!empty) begin
            pop      = 1'b1;
            drop_pop = 1'b1;
          end
        end
        default: ;
      endcase
    end

    always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + cnt_w'(1);
      else if (!push && pop) count_d = count_q - cnt_w'(1);
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= link_flit;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
        ready_q  <= 1'b0;
        drop_q   <= 1'b0;
        route_q  <= '0;
        state_q  <= StIdle;
      end else begin
        if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        count_q <= count_d;
        ready_q <= (count_d != full_count);
        drop_q  <= drop_pop;
        unique case (state_q)
          StIdle: begin
            if (!empty && is_head && routable) begin
              route_q <= dest_route;
              state_q <= StRoute;
            end else if (!empty && head_type == type_header) begin
              state_q <= StDrop;
            end
          end
          StRoute: begin
            if (transfer && is_tail) begin
              route_q <= '0;
              state_q <= StIdle;
            end
          end
          StDrop: begin
            if (!empty && head_type == type_last) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
